// File: rtl/lab61_io_pkg.sv
// Shared constants and types for the lab61 board I/O conditioning path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lab61_io_pkg;

    localparam int unsigned CLK_HZ                  = 50_000_000;
    localparam int unsigned DEBOUNCE_MS             = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Push-buttons are active-low on the board, so "released" is a high pin.
    localparam logic        KEY_RELEASED            = 1'b1;
    localparam int unsigned NUM_KEYS                = 2;

    // A channel is IDLE while its synchronized input agrees with the accepted
    // level, and COUNTING while the two disagree.
    typedef enum logic {
        CH_IDLE     = 1'b0,
        CH_COUNTING = 1'b1
    } ch_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, accepted level and fall pulse.
// Latency: DEBOUNCE_CYCLES + 2 edges pin-to-level; fall_pulse 1 edge after level falls.
// Backpressure: none; the channel samples every cycle and outputs are plain levels/pulses.
module debounce_ch
    import lab61_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RESET_VAL       = 1'b0,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic pin,
    output logic level,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             stable_nxt;
    ch_state_e        state;

    // Bring the asynchronous pin into the clock domain; nothing sits between the flops.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    // Channel state is implied by whether the synchronized input disagrees with the accepted level.
    always_comb begin
        state = (s2 != stable) ? CH_COUNTING : CH_IDLE;
    end

    // Next count/level: any agreement restarts the count, so a bounce earns no partial credit.
    always_comb begin
        cnt_nxt    = '0;
        stable_nxt = stable;
        case (state)
            CH_IDLE: begin
                cnt_nxt = '0;
            end
            CH_COUNTING: begin
                if (cnt == CNT_LAST) begin
                    stable_nxt = s2;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    // Accepted level, counter and the registered falling-edge pulse.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt         <= '0;
            stable      <= RESET_VAL;
            stable_prev <= RESET_VAL;
            fall_pulse  <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            stable      <= stable_nxt;
            stable_prev <= stable;
            fall_pulse  <= stable_prev & ~stable;
        end
    end

    assign level = stable;

endmodule

// File: rtl/lab61_input_conditioner.sv
// Synchronizes and debounces the two push-buttons and the slide switches feeding the lab61 SoC PIOs.
// Latency: DEBOUNCE_CYCLES + 2 edges pin-to-export; press pulse 1 edge after the key export falls.
// Backpressure: none; all channels run in parallel every cycle with no arbitration.
module lab61_input_conditioner
    import lab61_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SW_WIDTH        = 8,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [1:0]          key_n_pin,
    input  logic [SW_WIDTH-1:0] sw_pin,
    output logic                key0_wire_export,
    output logic                key1_wire_export,
    output logic [SW_WIDTH-1:0] switches_wire_export,
    output logic [1:0]          key_press_pulse
);

    logic [NUM_KEYS-1:0] key_level;
    // Switches never need a press pulse; the channel still produces one.
    logic [SW_WIDTH-1:0] sw_fall_unused;

    // Key channels idle at "released" so reset never looks like a press.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (KEY_RELEASED),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .pin           (key_n_pin[k]),
            .level         (key_level[k]),
            .fall_pulse    (key_press_pulse[k])
        );
    end

    // Switch channels idle low.
    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .pin           (sw_pin[i]),
            .level         (switches_wire_export[i]),
            .fall_pulse    (sw_fall_unused[i])
        );
    end

    assign key0_wire_export = key_level[0];
    assign key1_wire_export = key_level[1];

endmodule

// File: tb/tb_lab61_input_conditioner.sv
module tb_lab61_input_conditioner;

    localparam int N   = 4;
    localparam int SW  = 8;
    localparam int NCH = SW + 2;
    localparam logic [NCH-1:0] RST_VEC = {{SW{1'b0}}, 2'b11};

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic [1:0]    key_n_pin;
    logic [SW-1:0] sw_pin;
    logic          key0_wire_export;
    logic          key1_wire_export;
    logic [SW-1:0] switches_wire_export;
    logic [1:0]    key_press_pulse;

    lab61_input_conditioner #(
        .DEBOUNCE_CYCLES (N),
        .SW_WIDTH        (SW)
    ) dut (
        .clk_clk              (clk_clk),
        .reset_reset_n        (reset_reset_n),
        .key_n_pin            (key_n_pin),
        .sw_pin               (sw_pin),
        .key0_wire_export     (key0_wire_export),
        .key1_wire_export     (key1_wire_export),
        .switches_wire_export (switches_wire_export),
        .key_press_pulse      (key_press_pulse)
    );

    always #5 clk_clk = ~clk_clk;

    int tests = 0;
    int fails = 0;
    int edges = 0;
    int pcnt0 = 0;
    int lat;

    // Reference model: pins reach the decision point two edges late; a channel takes the
    // opposite level once the last N synchronized samples all disagree with its current level.
    logic [NCH-1:0] m_s1, m_s2, m_stable;
    logic [1:0]     m_fell, m_pulse;
    logic [NCH-1:0] win[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1     = RST_VEC;
        m_s2     = RST_VEC;
        m_stable = RST_VEC;
        m_fell   = 2'b00;
        m_pulse  = 2'b00;
        win.delete();
    endtask

    task automatic model_edge();
        logic [NCH-1:0] nxt;
        bit all_diff;
        if (!reset_reset_n) begin
            model_reset();
            return;
        end
        win.push_back(m_s2);
        if (win.size() > N) win.delete(0);
        m_pulse = m_fell;
        nxt = m_stable;
        if (win.size() == N) begin
            for (int ch = 0; ch < NCH; ch++) begin
                all_diff = 1'b1;
                foreach (win[j]) if (win[j][ch] == m_stable[ch]) all_diff = 1'b0;
                if (all_diff) nxt[ch] = ~m_stable[ch];
            end
        end
        m_fell   = m_stable[1:0] & ~nxt[1:0];
        m_stable = nxt;
        m_s2     = m_s1;
        m_s1     = {sw_pin, key_n_pin};
    endtask

    // Drive pins for one cycle, advance the model at the edge, compare just after it.
    task automatic step(input logic [1:0] k, input logic [SW-1:0] s);
        key_n_pin = k;
        sw_pin    = s;
        @(posedge clk_clk);
        edges++;
        model_edge();
        #1;
        chk("exports", {switches_wire_export, key1_wire_export, key0_wire_export}, m_stable);
        chk("pulse", key_press_pulse, m_pulse);
        if (key_press_pulse[0]) pcnt0++;
        @(negedge clk_clk);
    endtask

    // Hold a pin pattern until the chosen key export reaches val; bounded at 20 edges.
    task automatic run_until(input int idx, input logic val, input logic [1:0] k,
                             input logic [SW-1:0] s, output int l);
        int t0;
        t0 = edges;
        for (int i = 0; i < 20; i++) begin
            step(k, s);
            if (((idx == 0) ? key0_wire_export : key1_wire_export) == val) break;
        end
        l = edges - t0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] rp;
        logic [1:0] kb;

        key_n_pin     = 2'b11;
        sw_pin        = '0;
        reset_reset_n = 1'b1;
        model_reset();

        // Reset asserted mid-cycle takes effect with no clock edge.
        #12 reset_reset_n = 1'b0;
        #1;
        chk("rst_key0", key0_wire_export, 1'b1);
        chk("rst_key1", key1_wire_export, 1'b1);
        chk("rst_sw", switches_wire_export, 8'h00);
        chk("rst_pulse", key_press_pulse, 2'b00);
        @(negedge clk_clk);
        step(2'b11, 8'h00);
        step(2'b11, 8'h00);
        reset_reset_n = 1'b1;
        step(2'b11, 8'h00);

        // Clean press on KEY0.
        run_until(0, 1'b0, 2'b10, 8'h00, lat);
        chk("press_lat", lat, 6);
        chk("press_key1_idle", key1_wire_export, 1'b1);
        step(2'b10, 8'h00);
        chk("press_pulse_hi", key_press_pulse, 2'b01);
        step(2'b10, 8'h00);
        chk("press_pulse_lo", key_press_pulse, 2'b00);

        // KEY1 bounces 0,1,0,1 at 2-cycle intervals, then holds 0.
        kb = 2'b10;
        for (int i = 0; i < 8; i++) begin
            kb = 2'b10 >> ((i / 2) % 2 == 0);
            step({(i / 2) % 2 == 1, 1'b0}, 8'h00);
            chk("bounce_stay", key1_wire_export, 1'b1);
        end
        run_until(1, 1'b0, 2'b00, 8'h00, lat);
        chk("bounce_lat", lat, 6);
        step(2'b00, 8'h00);
        chk("bounce_pulse_hi", key_press_pulse, 2'b10);
        step(2'b00, 8'h00);
        chk("bounce_pulse_lo", key_press_pulse, 2'b00);

        // Switches 00 -> A5 with bit 2 low for two cycles starting at cycle 1.
        step(2'b00, 8'hA5);
        step(2'b00, 8'hA1);
        step(2'b00, 8'hA1);
        step(2'b00, 8'hA5);
        step(2'b00, 8'hA5);
        chk("sw_edge5", switches_wire_export, 8'h00);
        step(2'b00, 8'hA5);
        chk("sw_edge6", switches_wire_export, 8'hA1);
        step(2'b00, 8'hA5);
        step(2'b00, 8'hA5);
        chk("sw_edge8", switches_wire_export, 8'hA1);
        step(2'b00, 8'hA5);
        chk("sw_edge9", switches_wire_export, 8'hA5);

        // Release KEY0: rises after 6 edges, no pulse.
        pcnt0 = 0;
        run_until(0, 1'b1, 2'b01, 8'hA5, lat);
        chk("release_lat", lat, 6);
        step(2'b01, 8'hA5);
        step(2'b01, 8'hA5);
        chk("release_no_pulse", pcnt0, 0);
        run_until(1, 1'b1, 2'b11, 8'hA5, lat);
        chk("release1_lat", lat, 6);

        // Reset while KEY0's count is at 2, key still held.
        for (int i = 0; i < 4; i++) step(2'b10, 8'hA5);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("midrst_key0", key0_wire_export, 1'b1);
        chk("midrst_key1", key1_wire_export, 1'b1);
        chk("midrst_sw", switches_wire_export, 8'h00);
        chk("midrst_pulse", key_press_pulse, 2'b00);
        @(negedge clk_clk);
        step(2'b10, 8'h00);
        step(2'b10, 8'h00);
        reset_reset_n = 1'b1;
        pcnt0 = 0;
        run_until(0, 1'b0, 2'b10, 8'h00, lat);
        chk("midrst_lat", lat, 6);
        for (int i = 0; i < 4; i++) step(2'b10, 8'h00);
        chk("midrst_one_pulse", pcnt0, 1);

        // Random pin activity on all channels against the model.
        rp = {sw_pin, key_n_pin};
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(4) == 0) rp[ch] = ~rp[ch];
            end
            step(rp[1:0], rp[NCH-1:2]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
